// File: rtl/fmap_collector.sv
// Collects a raster pixel stream into a double-buffered 2-D feature map.
// One bank fills while the other is held stable until the consumer acks it.
module fmap_collector #(
    parameter int IMGROW     = 32,
    parameter int IMGCOL     = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic signed [0:IMGROW-1][0:IMGCOL-1][DATA_WIDTH-1:0] fmap,
    output logic                   fmap_valid,
    input  logic                   fmap_ack,
    output logic [15:0]            frame_cnt,
    output logic                   sof_err
);

    localparam int ROW_W = (IMGROW > 1) ? $clog2(IMGROW) : 1;
    localparam int COL_W = (IMGCOL > 1) ? $clog2(IMGCOL) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMGROW - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMGCOL - 1);

    typedef enum logic {FILL, WAIT} state_t;

    state_t state;
    logic [0:IMGROW-1][0:IMGCOL-1][DATA_WIDTH-1:0] bank0, bank1;
    logic             wr_sel;
    logic [ROW_W-1:0] row, pr;
    logic [COL_W-1:0] col, pc;
    logic             last, accept, can_swap;

    // An sof pixel always lands at (0,0), whatever the counters say.
    always_comb begin
        pr       = in_sof ? '0 : row;
        pc       = in_sof ? '0 : col;
        last     = (pr == ROW_LAST) && (pc == COL_LAST);
        accept   = in_valid && in_ready;
        can_swap = !fmap_valid || fmap_ack;
    end

    assign fmap = wr_sel ? bank0 : bank1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= FILL;
            bank0      <= '0;
            bank1      <= '0;
            wr_sel     <= 1'b0;
            row        <= '0;
            col        <= '0;
            in_ready   <= 1'b0;
            fmap_valid <= 1'b0;
            frame_cnt  <= '0;
            sof_err    <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    in_ready <= 1'b1;
                    if (fmap_ack && !(accept && last))
                        fmap_valid <= 1'b0;
                    if (accept) begin
                        if (wr_sel) bank1[pr][pc] <= in_data;
                        else        bank0[pr][pc] <= in_data;
                        if (in_sof && (row != '0 || col != '0))
                            sof_err <= 1'b1;
                        if (last) begin
                            row <= '0;
                            col <= '0;
                            if (can_swap) begin
                                wr_sel     <= ~wr_sel;
                                fmap_valid <= 1'b1;
                                frame_cnt  <= frame_cnt + 16'd1;
                            end else begin
                                state    <= WAIT;
                                in_ready <= 1'b0;
                            end
                        end else if (pc == COL_LAST) begin
                            row <= pr + ROW_W'(1);
                            col <= '0;
                        end else begin
                            row <= pr;
                            col <= pc + COL_W'(1);
                        end
                    end
                end
                WAIT: begin
                    // fmap_valid is necessarily 1 here, so any ack frees the read bank.
                    if (fmap_ack) begin
                        wr_sel    <= ~wr_sel;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= FILL;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_fmap_collector.sv
// Bench for fmap_collector: frames are assembled by a pixel-position model
// and compared against the presented fmap at each completion point.
module tb_fmap_collector;
    localparam int R = 4;
    localparam int C = 4;
    localparam int W = 8;
    typedef logic [0:R-1][0:C-1][W-1:0] frame_t;

    logic clk = 1'b0, rst = 1'b0;
    logic in_valid = 1'b0, in_sof = 1'b0, fmap_ack = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic in_ready, fmap_valid, sof_err;
    logic [15:0] frame_cnt;
    frame_t fmap;

    int n_cmp = 0, n_bad = 0;

    frame_t m_img, shown;
    frame_t m_done[$];
    int     m_pos = 0;
    bit     m_sof_err = 0;
    int     exp_cnt = 0;

    fmap_collector #(.IMGROW(R), .IMGCOL(C), .DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .in_ready(in_ready), .fmap(fmap), .fmap_valid(fmap_valid), .fmap_ack(fmap_ack),
        .frame_cnt(frame_cnt), .sof_err(sof_err)
    );

    always #5 clk = ~clk;

    function automatic void model_accept(input logic [W-1:0] d, input logic sof);
        if (sof) begin
            if (m_pos != 0) m_sof_err = 1;
            m_pos = 0;
        end
        m_img[m_pos / C][m_pos % C] = d;
        m_pos++;
        if (m_pos == R * C) begin
            m_pos = 0;
            m_done.push_back(m_img);
        end
    endfunction

    function automatic void model_reset();
        m_pos = 0;
        m_sof_err = 0;
        m_done.delete();
        m_img = '0;
        exp_cnt = 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one pixel, returns once it is accepted (or the wait budget runs out).
    task automatic send(input logic [W-1:0] d, input logic sof, input logic ack, output int waits);
        waits = 0;
        in_valid = 1'b1; in_data = d; in_sof = sof; fmap_ack = ack;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 50) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", in_ready, waits);
        end else begin
            @(posedge clk);
            model_accept(d, sof);
        end
        #1;
        in_valid = 1'b0; in_sof = 1'b0; fmap_ack = 1'b0;
    endtask

    task automatic pulse_ack();
        fmap_ack = 1'b1;
        tick(1);
        fmap_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_cmp++; if (fmap !== '0) begin n_bad++; $display("FAIL reset_fmap: got %h want 0", fmap); end
        n_cmp++; if (fmap_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", fmap_valid); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (sof_err !== 1'b0) begin n_bad++; $display("FAIL reset_sof_err: got %b want 0", sof_err); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        tick(1);
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_reset: got %b want 1", in_ready); end
    endtask

    task automatic test_fill();
        int w;
        for (int i = 0; i < R * C; i++) begin
            send(W'(i - 8), i == 0, 1'b0, w);
            if (i == R * C - 2) begin
                n_cmp++; if (fmap_valid !== 1'b0) begin n_bad++; $display("FAIL fill_early_valid: got %b want 0", fmap_valid); end
            end
        end
        exp_cnt++;
        shown = m_done.pop_front();
        n_cmp++; if (fmap_valid !== 1'b1) begin n_bad++; $display("FAIL fill_valid: got %b want 1", fmap_valid); end
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL fill_fmap: got %h want %h", fmap, shown); end
        n_cmp++; if ($signed(fmap[0][0]) !== -8) begin n_bad++; $display("FAIL fill_first: got %0d want -8", $signed(fmap[0][0])); end
        n_cmp++; if ($signed(fmap[R-1][C-1]) !== 7) begin n_bad++; $display("FAIL fill_last: got %0d want 7", $signed(fmap[R-1][C-1])); end
        n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL fill_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
        n_cmp++; if (sof_err !== 1'b0) begin n_bad++; $display("FAIL fill_sof_err: got %b want 0", sof_err); end
    endtask

    task automatic test_hold();
        int w;
        for (int i = 0; i < R * C; i++) send(W'($urandom), i == 0, 1'b0, w);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_ready: got %b want 0", in_ready); end
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL hold_fmap: got %h want %h", fmap, shown); end
        tick(3);
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL hold_stable: got %h want %h", fmap, shown); end
        n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL hold_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
        pulse_ack();
        exp_cnt++;
        shown = m_done.pop_front();
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL hold_swap_fmap: got %h want %h", fmap, shown); end
        n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL hold_swap_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_swap_ready: got %b want 1", in_ready); end
        n_cmp++; if (fmap_valid !== 1'b1) begin n_bad++; $display("FAIL hold_swap_valid: got %b want 1", fmap_valid); end
    endtask

    task automatic test_back_to_back();
        int w, max_w;
        time t0;
        max_w = 0;
        t0 = $time;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < R * C; i++) begin
                send(W'($urandom), 1'b0, i == R * C - 1, w);
                if (w > max_w) max_w = w;
            end
            exp_cnt++;
            shown = m_done.pop_front();
            n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL b2b_fmap%0d: got %h want %h", f, fmap, shown); end
            n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL b2b_cnt%0d: got %0d want %0d", f, frame_cnt, exp_cnt); end
            n_cmp++; if (fmap_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d: got %b want 1", f, fmap_valid); end
        end
        n_cmp++; if (max_w != 0) begin n_bad++; $display("FAIL b2b_stall: got %0d stall cycles want 0", max_w); end
        n_cmp++; if ($time - t0 != 3 * R * C * 10) begin n_bad++; $display("FAIL b2b_time: got %0t want %0d", $time - t0, 3 * R * C * 10); end
        pulse_ack();
        n_cmp++; if (fmap_valid !== 1'b0) begin n_bad++; $display("FAIL release_valid: got %b want 0", fmap_valid); end
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL release_fmap: got %h want %h", fmap, shown); end
        pulse_ack();
        n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL idle_ack_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
        n_cmp++; if (fmap_valid !== 1'b0) begin n_bad++; $display("FAIL idle_ack_valid: got %b want 0", fmap_valid); end
    endtask

    task automatic test_sof_restart();
        int w;
        for (int i = 0; i < 5; i++) send(W'($urandom), 1'b0, 1'b0, w);
        send(8'h55, 1'b1, 1'b0, w);
        for (int i = 0; i < R * C - 1; i++) send(W'($urandom), 1'b0, 1'b0, w);
        exp_cnt++;
        shown = m_done.pop_front();
        n_cmp++; if (sof_err !== m_sof_err) begin n_bad++; $display("FAIL sof_err: got %b want %b", sof_err, m_sof_err); end
        n_cmp++; if (fmap[0][0] !== 8'h55) begin n_bad++; $display("FAIL sof_first: got %h want 55", fmap[0][0]); end
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL sof_fmap: got %h want %h", fmap, shown); end
        n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL sof_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
        pulse_ack();
        // sof on the last raster position restarts the frame instead of completing it
        for (int i = 0; i < R * C - 1; i++) send(W'($urandom), 1'b0, 1'b0, w);
        send(W'($urandom), 1'b1, 1'b0, w);
        n_cmp++; if (fmap_valid !== 1'b0) begin n_bad++; $display("FAIL sof_last_noswap: got %b want 0", fmap_valid); end
        for (int i = 0; i < R * C - 1; i++) send(W'($urandom), 1'b0, 1'b0, w);
        exp_cnt++;
        shown = m_done.pop_front();
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL sof_last_fmap: got %h want %h", fmap, shown); end
        n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL sof_last_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
        pulse_ack();
    endtask

    task automatic test_random();
        int w;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < R * C; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    in_data = W'($urandom);
                    tick(1);
                end
                send(W'($urandom), (i == 0) && ($urandom_range(0, 1) == 1), 1'b0, w);
            end
            exp_cnt++;
            shown = m_done.pop_front();
            n_cmp++; if (fmap_valid !== 1'b1) begin n_bad++; $display("FAIL rand_valid%0d: got %b want 1", f, fmap_valid); end
            n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL rand_fmap%0d: got %h want %h", f, fmap, shown); end
            n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL rand_cnt%0d: got %0d want %0d", f, frame_cnt, exp_cnt); end
            pulse_ack();
            n_cmp++; if (fmap_valid !== 1'b0) begin n_bad++; $display("FAIL rand_release%0d: got %b want 0", f, fmap_valid); end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        for (int i = 0; i < R * C; i++) send(W'($urandom), 1'b0, 1'b0, w);
        n_cmp++; if (fmap_valid !== 1'b1) begin n_bad++; $display("FAIL pre_rst_valid: got %b want 1", fmap_valid); end
        for (int i = 0; i < 9; i++) send(W'($urandom), 1'b0, 1'b0, w);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (fmap !== '0) begin n_bad++; $display("FAIL mid_rst_fmap: got %h want 0", fmap); end
        n_cmp++; if (fmap_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", fmap_valid); end
        n_cmp++; if (frame_cnt !== 16'd0) begin n_bad++; $display("FAIL mid_rst_cnt: got %0d want 0", frame_cnt); end
        n_cmp++; if (sof_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sof_err: got %b want 0", sof_err); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        tick(1);
        for (int i = 0; i < R * C; i++) send(W'($urandom), i == 0, 1'b0, w);
        exp_cnt++;
        shown = m_done.pop_front();
        n_cmp++; if (fmap !== shown) begin n_bad++; $display("FAIL post_rst_fmap: got %h want %h", fmap, shown); end
        n_cmp++; if (frame_cnt !== 16'(exp_cnt)) begin n_bad++; $display("FAIL post_rst_cnt: got %0d want %0d", frame_cnt, exp_cnt); end
        n_cmp++; if (sof_err !== 1'b0) begin n_bad++; $display("FAIL post_rst_sof_err: got %b want 0", sof_err); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_hold();
        test_back_to_back();
        test_sof_restart();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
